// File: rtl/mac_pkg.sv
// mac_pkg: shared state type and width helpers for the matrix-vector MAC sequencer
package mac_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, OUT} mac_seq_state_t;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int ACC_WIDTH = 3 * DEF_DATA_WIDTH;
    function automatic int acc_width(input int dw);
        return 3 * dw;
    endfunction
    function automatic int cnt_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic int a_addr_width(input int rows, input int cols);
        return cnt_width(rows * cols);
    endfunction
endpackage

// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if: operand memory, MAC and result stream signals of the sequencer
interface mac_seq_ctrl_if #(parameter int DATA_WIDTH = 8, parameter int ROWS = 8, parameter int COLS = 8);
    import mac_pkg::*;
    localparam int AW = a_addr_width(ROWS, COLS);
    localparam int XW = cnt_width(COLS);
    localparam int RW = cnt_width(ROWS);
    localparam int AccW = acc_width(DATA_WIDTH);
    logic [AW-1:0] a_addr;
    logic [XW-1:0] x_addr;
    logic rd_en;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic [DATA_WIDTH-1:0] x_rdata;
    logic mac_en;
    logic mac_clr;
    logic [DATA_WIDTH-1:0] mac_ain;
    logic [DATA_WIDTH-1:0] mac_bin;
    logic [AccW-1:0] mac_cout;
    logic y_valid;
    logic y_ready;
    logic [AccW-1:0] y_data;
    logic [RW-1:0] y_row;
    modport master (
        output a_addr, x_addr, rd_en, mac_en, mac_clr, mac_ain, mac_bin, y_valid, y_data, y_row,
        input a_rdata, x_rdata, mac_cout, y_ready
    );
    modport slave (
        input a_addr, x_addr, rd_en, mac_en, mac_clr, mac_ain, mac_bin, y_valid, y_data, y_row,
        output a_rdata, x_rdata, mac_cout, y_ready
    );
endinterface

// File: rtl/mac_seq_cnt.sv
// mac_seq_cnt: row/col counter pair with wrap and last-flags
module mac_seq_cnt import mac_pkg::*; #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic row_clr,
    input  logic row_inc,
    input  logic col_clr,
    input  logic col_inc,
    output logic [cnt_width(ROWS)-1:0] row,
    output logic [cnt_width(COLS)-1:0] col,
    output logic row_last,
    output logic col_last
);
    localparam int RW = cnt_width(ROWS);
    localparam int CW = cnt_width(COLS);
    assign row_last = row == RW'(ROWS - 1);
    assign col_last = col == CW'(COLS - 1);
    always_ff @(posedge clk) begin
        if (rst || row_clr) row <= '0;
        else if (row_inc) row <= row_last ? '0 : row + 1'b1;
        if (rst || col_clr) col <= '0;
        else if (col_inc) col <= col_last ? '0 : col + 1'b1;
    end
endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one MAC through y = A*x row by row onto a valid/ready stream
module mac_seq_ctrl import mac_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    mac_seq_ctrl_if.master bus
);
    localparam int RW = cnt_width(ROWS);
    localparam int CW = cnt_width(COLS);
    localparam int AW = a_addr_width(ROWS, COLS);
    mac_seq_state_t state, next;
    logic row_clr, row_inc, col_clr, col_inc, row_last, col_last;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    mac_seq_cnt #(.ROWS(ROWS), .COLS(COLS)) cnt (
        .clk(clk), .rst(rst),
        .row_clr(row_clr), .row_inc(row_inc), .col_clr(col_clr), .col_inc(col_inc),
        .row(row), .col(col), .row_last(row_last), .col_last(col_last)
    );
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : next;
        bus.mac_en <= !rst && state == FETCH;
        done <= !rst && state == OUT && bus.y_ready && row_last;
    end
    always_comb begin
        next = state;
        row_clr = 1'b0;
        row_inc = 1'b0;
        col_clr = 1'b0;
        col_inc = 1'b0;
        unique case (state)
            IDLE: begin
                row_clr = start;
                next = start ? CLEAR : IDLE;
            end
            CLEAR: begin
                col_clr = 1'b1;
                next = FETCH;
            end
            FETCH: begin
                col_inc = 1'b1;
                next = col_last ? DRAIN : FETCH;
            end
            DRAIN: next = OUT;
            OUT: begin
                row_inc = bus.y_ready && !row_last;
                next = !bus.y_ready ? OUT : row_last ? IDLE : CLEAR;
            end
            default: next = IDLE;
        endcase
    end
    assign busy = state != IDLE;
    assign bus.rd_en = state == FETCH;
    assign bus.mac_clr = state == CLEAR;
    assign bus.y_valid = state == OUT;
    assign bus.a_addr = AW'(int'(row) * COLS + int'(col));
    assign bus.x_addr = col;
    assign bus.y_row = row;
    assign bus.y_data = bus.mac_cout;
    assign bus.mac_ain = bus.a_rdata;
    assign bus.mac_bin = bus.x_rdata;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: scoreboard bench with behavioural memories and MAC around the sequencer
module tb_mac_seq_ctrl;
    typedef struct {int row; logic [23:0] data;} exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic busy, done, busy2, done2;
    logic armed = 1'b0;
    logic prev_rd = 1'b0;
    logic [23:0] acc, acc2;
    logic [7:0] amem [6];
    logic [7:0] xmem [3];
    exp_t q [$];
    exp_t mon_e;
    int errors = 0;
    int checks = 0;
    int n;
    logic [23:0] yd;
    logic yr;

    mac_seq_ctrl_if #(.DATA_WIDTH(8), .ROWS(2), .COLS(3)) bus ();
    mac_seq_ctrl_if #(.DATA_WIDTH(8), .ROWS(1), .COLS(8)) bus2 ();

    mac_seq_ctrl #(.DATA_WIDTH(8), .ROWS(2), .COLS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus)
    );
    mac_seq_ctrl #(.DATA_WIDTH(8), .ROWS(1), .COLS(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .bus(bus2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.a_rdata <= amem[bus.a_addr];
            bus.x_rdata <= xmem[bus.x_addr];
        end
        if (bus2.rd_en) begin
            bus2.a_rdata <= 8'hFF;
            bus2.x_rdata <= 8'hFF;
        end
        if (bus.mac_clr) acc <= '0;
        else if (bus.mac_en) acc <= acc + 24'(bus.mac_ain) * 24'(bus.mac_bin);
        if (bus2.mac_clr) acc2 <= '0;
        else if (bus2.mac_en) acc2 <= acc2 + 24'(bus2.mac_ain) * 24'(bus2.mac_bin);
        prev_rd <= rst ? 1'b0 : bus.rd_en;
    end
    assign bus.mac_cout = acc;
    assign bus2.mac_cout = acc2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("en_delay", bus.mac_en, prev_rd);
            chk("en_clr_excl", bus.mac_en & bus.mac_clr, 0);
            if (!rst && bus.y_valid && bus.y_ready) begin
                if (q.size() == 0) chk("sb_empty", 1, 0);
                else begin
                    mon_e = q.pop_front();
                    chk("y_data", bus.y_data, mon_e.data);
                    chk("y_row", bus.y_row, mon_e.row);
                end
            end
        end
    end

    task automatic push_row(input int r);
        logic [23:0] s = '0;
        for (int c = 0; c < 3; c++) s += 24'(amem[r*3+c]) * 24'(xmem[c]);
        q.push_back('{r, s});
    endtask

    task automatic push_run();
        for (int r = 0; r < 2; r++) push_row(r);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 6; i++) amem[i] = 8'($urandom_range(1, 255));
        for (int i = 0; i < 3; i++) xmem[i] = 8'($urandom_range(1, 255));
    endtask

    task automatic wait_done(input string tag, input int budget, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!done && cnt < budget);
        if (!done) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        bus.y_ready = 1'b1;
        bus2.y_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_mac_en", bus.mac_en, 0);
        chk("rst_mac_clr", bus.mac_clr, 0);
        chk("rst_y_valid", bus.y_valid, 0);
        chk("rst_a_addr", bus.a_addr, 0);
        chk("rst_x_addr", bus.x_addr, 0);
        chk("rst_y_row", bus.y_row, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        armed = 1'b1;

        // all-255 operands over 8 columns on the second instance
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus2.y_valid && n < 30);
        chk("max_y_data", bus2.y_data, 24'h07F008);
        chk("max_y_row", bus2.y_row, 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!done2 && n < 10);
        chk("max_done", done2, 1);

        amem = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        xmem = '{8'd7, 8'd8, 8'd9};
        q.push_back('{0, 24'd50});
        q.push_back('{1, 24'd122});
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t1", 50, n);
        chk("t1_done_lat", n, 13);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);
        chk("t1_sb_left", q.size(), 0);

        fill_rand();
        push_run();
        bus.y_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.y_valid && n < 30);
        chk("stall_seen", bus.y_valid, 1);
        yd = bus.y_data;
        yr = bus.y_row;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", bus.y_valid, 1);
            chk("stall_data", bus.y_data, yd);
            chk("stall_row_hold", bus.y_row, yr);
            chk("stall_row", bus.y_row, 0);
            chk("stall_mac_en", bus.mac_en, 0);
        end
        @(posedge clk); #1;
        bus.y_ready = 1'b1;
        wait_done("stall", 60, n);
        chk("stall_sb_left", q.size(), 0);

        fill_rand();
        push_run();
        push_run();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        wait_done("held1", 50, n);
        chk("held1_lat", n, 13);
        @(posedge clk); #1;
        start = 1'b0;
        chk("held_restart_busy", busy, 1);
        wait_done("held2", 50, n);
        chk("held2_lat", n, 13);
        @(negedge clk);
        chk("held_sb_left", q.size(), 0);

        fill_rand();
        push_row(0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(bus.rd_en && bus.y_row == 1'b1) && n < 30);
        chk("rst_mid_fetch_row1", bus.rd_en, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_y_valid", bus.y_valid, 0);
        chk("mid_rst_rd_en", bus.rd_en, 0);
        chk("mid_rst_done", done, 0);
        repeat (4) begin
            @(negedge clk);
            chk("mid_rst_no_done", done, 0);
        end
        chk("mid_rst_sb_left", q.size(), 0);
        fill_rand();
        push_run();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("after_rst", 50, n);
        chk("after_rst_lat", n, 13);
        @(negedge clk);
        chk("after_rst_sb_left", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
